// File: rtl/riscv_pkg.sv
// Core-wide shared types: data-path width and the memory port arbiter's state/owner encodings.
package riscv_pkg;

  localparam int XLEN = 32;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_REQ,
    ARB_WAIT
  } arb_state_e;

  typedef enum logic {
    OWN_FETCH,
    OWN_DATA
  } arb_owner_e;

endpackage

// File: rtl/mem_watchdog.sv
// Cycle counter that flags a memory transaction stuck for TIMEOUT_CYCLES cycles.
module mem_watchdog #(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic clk_i,
  input  logic rstn_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expire_o
);

  localparam logic [15:0] LIMIT = 16'(TIMEOUT_CYCLES - 1);

  logic [15:0] count_reg;

  // Expire fires during the TIMEOUT_CYCLES-th enabled cycle after a clear.
  assign expire_o = enable_i && (count_reg == LIMIT);

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      count_reg <= '0;
    end else if (clear_i) begin
      count_reg <= '0;
    end else if (enable_i && !expire_o) begin
      count_reg <= count_reg + 16'd1;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares the unified memory port between fetch and load/store, one transaction at a time,
// with a watchdog that aborts hung transactions.
module mem_port_arbiter
  import riscv_pkg::*;
#(
  parameter int ARB_MODE       = 0,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            if_req_i,
  input  logic [XLEN-1:0] if_addr_i,
  output logic            if_gnt_o,
  output logic            if_rvalid_o,
  output logic [XLEN-1:0] if_rdata_o,
  input  logic            d_req_i,
  input  logic            d_we_i,
  input  logic [3:0]      d_be_i,
  input  logic [XLEN-1:0] d_addr_i,
  input  logic [XLEN-1:0] d_wdata_i,
  output logic            d_gnt_o,
  output logic            d_rvalid_o,
  output logic [XLEN-1:0] d_rdata_o,
  output logic            mem_req_o,
  output logic            mem_we_o,
  output logic [3:0]      mem_be_o,
  output logic [XLEN-1:0] mem_addr_o,
  output logic [XLEN-1:0] mem_wdata_o,
  input  logic            mem_gnt_i,
  input  logic            mem_rvalid_i,
  input  logic [XLEN-1:0] mem_rdata_i,
  output logic            stall_o,
  output logic            err_o
);

  arb_state_e      state_reg, state_next;
  arb_owner_e      owner_reg, owner_next;
  arb_owner_e      last_owner_reg, last_owner_next;
  logic            mem_req_reg, mem_req_next;
  logic            mem_we_reg, mem_we_next;
  logic [3:0]      mem_be_reg, mem_be_next;
  logic [XLEN-1:0] mem_addr_reg, mem_addr_next;
  logic [XLEN-1:0] mem_wdata_reg, mem_wdata_next;
  logic            if_rvalid_reg, if_rvalid_next;
  logic            d_rvalid_reg, d_rvalid_next;
  logic [XLEN-1:0] if_rdata_reg, if_rdata_next;
  logic [XLEN-1:0] d_rdata_reg, d_rdata_next;
  logic            err_reg, err_next;

  logic            pick_data;
  logic            grant_any;
  logic            wd_expire;
  logic            resp_fire;
  logic            resp_err;
  logic [XLEN-1:0] resp_data;

  // Round-robin only matters on a tie: the side that did not go last wins.
  always_comb begin
    if (ARB_MODE == 0) begin
      pick_data = d_req_i;
    end else begin
      pick_data = d_req_i && (!if_req_i || (last_owner_reg == OWN_FETCH));
    end
  end

  // No grants while reset is held so the requesters never see a lost handshake.
  assign grant_any = rstn_i && (state_reg == ARB_IDLE) && (if_req_i || d_req_i);
  assign d_gnt_o   = grant_any && pick_data;
  assign if_gnt_o  = grant_any && !pick_data;
  assign stall_o   = (state_reg != ARB_IDLE) || grant_any;

  mem_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk_i   (clk_i),
    .rstn_i  (rstn_i),
    .clear_i (grant_any),
    .enable_i(state_reg != ARB_IDLE),
    .expire_o(wd_expire)
  );

  always_comb begin
    state_next      = state_reg;
    owner_next      = owner_reg;
    last_owner_next = last_owner_reg;
    mem_req_next    = mem_req_reg;
    mem_we_next     = mem_we_reg;
    mem_be_next     = mem_be_reg;
    mem_addr_next   = mem_addr_reg;
    mem_wdata_next  = mem_wdata_reg;
    if_rvalid_next  = 1'b0;
    d_rvalid_next   = 1'b0;
    if_rdata_next   = if_rdata_reg;
    d_rdata_next    = d_rdata_reg;
    err_next        = 1'b0;
    resp_fire       = 1'b0;
    resp_err        = 1'b0;
    resp_data       = '0;

    case (state_reg)
      ARB_IDLE: begin
        if (grant_any) begin
          owner_next      = pick_data ? OWN_DATA : OWN_FETCH;
          last_owner_next = pick_data ? OWN_DATA : OWN_FETCH;
          mem_req_next    = 1'b1;
          mem_we_next     = pick_data ? d_we_i : 1'b0;
          mem_be_next     = pick_data ? d_be_i : 4'hF;
          mem_addr_next   = pick_data ? d_addr_i : if_addr_i;
          mem_wdata_next  = pick_data ? d_wdata_i : '0;
          state_next      = ARB_REQ;
        end
      end
      ARB_REQ: begin
        if (wd_expire) begin
          resp_fire = 1'b1;
          resp_err  = 1'b1;
        end else if (mem_gnt_i) begin
          mem_req_next = 1'b0;
          state_next   = ARB_WAIT;
        end
      end
      ARB_WAIT: begin
        // A genuine response beats a same-cycle timeout.
        if (mem_rvalid_i) begin
          resp_fire = 1'b1;
          resp_data = mem_we_reg ? '0 : mem_rdata_i;
        end else if (wd_expire) begin
          resp_fire = 1'b1;
          resp_err  = 1'b1;
        end
      end
      default: begin
        state_next = ARB_IDLE;
      end
    endcase

    if (resp_fire) begin
      state_next   = ARB_IDLE;
      mem_req_next = 1'b0;
      err_next     = resp_err;
      if (owner_reg == OWN_DATA) begin
        d_rvalid_next = 1'b1;
        d_rdata_next  = resp_data;
      end else begin
        if_rvalid_next = 1'b1;
        if_rdata_next  = resp_data;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      state_reg      <= ARB_IDLE;
      owner_reg      <= OWN_FETCH;
      last_owner_reg <= OWN_FETCH;
      mem_req_reg    <= 1'b0;
      mem_we_reg     <= 1'b0;
      mem_be_reg     <= '0;
      mem_addr_reg   <= '0;
      mem_wdata_reg  <= '0;
      if_rvalid_reg  <= 1'b0;
      d_rvalid_reg   <= 1'b0;
      if_rdata_reg   <= '0;
      d_rdata_reg    <= '0;
      err_reg        <= 1'b0;
    end else begin
      state_reg      <= state_next;
      owner_reg      <= owner_next;
      last_owner_reg <= last_owner_next;
      mem_req_reg    <= mem_req_next;
      mem_we_reg     <= mem_we_next;
      mem_be_reg     <= mem_be_next;
      mem_addr_reg   <= mem_addr_next;
      mem_wdata_reg  <= mem_wdata_next;
      if_rvalid_reg  <= if_rvalid_next;
      d_rvalid_reg   <= d_rvalid_next;
      if_rdata_reg   <= if_rdata_next;
      d_rdata_reg    <= d_rdata_next;
      err_reg        <= err_next;
    end
  end

  assign mem_req_o   = mem_req_reg;
  assign mem_we_o    = mem_we_reg;
  assign mem_be_o    = mem_be_reg;
  assign mem_addr_o  = mem_addr_reg;
  assign mem_wdata_o = mem_wdata_reg;
  assign if_rvalid_o = if_rvalid_reg;
  assign if_rdata_o  = if_rdata_reg;
  assign d_rvalid_o  = d_rvalid_reg;
  assign d_rdata_o   = d_rdata_reg;
  assign err_o       = err_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: fixed-priority instance u0 and round-robin instance u1,
// a small memory responder and a response scoreboard.
module tb_mem_port_arbiter;
  import riscv_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rstn;
  logic        if_req, d_req, d_we;
  logic [3:0]  d_be;
  logic [31:0] if_addr, d_addr, d_wdata;

  logic        if_gnt [2], if_rvalid [2], d_gnt [2], d_rvalid [2];
  logic        mem_req [2], mem_we [2], stall [2], err [2];
  logic        mem_gnt [2], mem_rvalid [2];
  logic [3:0]  mem_be [2];
  logic [31:0] if_rdata [2], d_rdata [2], mem_addr [2], mem_wdata [2], mem_rdata [2];

  mem_port_arbiter #(.ARB_MODE(0), .TIMEOUT_CYCLES(8)) u0 (
    .clk_i(clk), .rstn_i(rstn),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt[0]),
    .if_rvalid_o(if_rvalid[0]), .if_rdata_o(if_rdata[0]),
    .d_req_i(d_req), .d_we_i(d_we), .d_be_i(d_be), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_gnt_o(d_gnt[0]), .d_rvalid_o(d_rvalid[0]), .d_rdata_o(d_rdata[0]),
    .mem_req_o(mem_req[0]), .mem_we_o(mem_we[0]), .mem_be_o(mem_be[0]),
    .mem_addr_o(mem_addr[0]), .mem_wdata_o(mem_wdata[0]),
    .mem_gnt_i(mem_gnt[0]), .mem_rvalid_i(mem_rvalid[0]), .mem_rdata_i(mem_rdata[0]),
    .stall_o(stall[0]), .err_o(err[0])
  );

  mem_port_arbiter #(.ARB_MODE(1), .TIMEOUT_CYCLES(8)) u1 (
    .clk_i(clk), .rstn_i(rstn),
    .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt[1]),
    .if_rvalid_o(if_rvalid[1]), .if_rdata_o(if_rdata[1]),
    .d_req_i(d_req), .d_we_i(d_we), .d_be_i(d_be), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
    .d_gnt_o(d_gnt[1]), .d_rvalid_o(d_rvalid[1]), .d_rdata_o(d_rdata[1]),
    .mem_req_o(mem_req[1]), .mem_we_o(mem_we[1]), .mem_be_o(mem_be[1]),
    .mem_addr_o(mem_addr[1]), .mem_wdata_o(mem_wdata[1]),
    .mem_gnt_i(mem_gnt[1]), .mem_rvalid_i(mem_rvalid[1]), .mem_rdata_i(mem_rdata[1]),
    .stall_o(stall[1]), .err_o(err[1])
  );

  typedef struct {
    arb_owner_e  own;
    logic [31:0] data;
    logic        err;
    int          cyc;
  } exp_t;

  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          sel = 0;
  int          gnt_wait = 0;
  bit          never_gnt = 0;
  bit          resp_en = 1;
  bit          force_rvalid = 0;
  logic [31:0] rdata_cfg = '0;
  int          wcnt = 0;
  bit          resp_pend = 0;
  bit          keep_req = 0;
  bit          drop_all = 0;
  bit          pend_if = 0;
  bit          pend_d = 0;
  bit          got_if_gnt = 0;
  bit          got_d_gnt = 0;
  int          exp_lat = -1;
  int          n_grants = 0;
  int          n_resp = 0;
  int          d_gnt_cyc = 0;
  int          f_gnt_cyc = 0;
  exp_t        sb [$];
  arb_owner_e  gnt_order [$];

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [159:0] pack_outs(input int k);
    return {20'd0, if_gnt[k], if_rvalid[k], if_rdata[k], d_gnt[k], d_rvalid[k], d_rdata[k],
            mem_req[k], mem_we[k], mem_be[k], mem_addr[k], mem_wdata[k], stall[k], err[k]};
  endfunction

  // One clock: drive requesters and the memory model at +1, observe and score at +2.
  task automatic tick();
    exp_t       e;
    arb_owner_e own;
    @(posedge clk);
    cyc++;
    #1;
    if (drop_all) begin
      if_req = 1'b0; d_req = 1'b0; drop_all = 0;
    end else if (!keep_req) begin
      if (got_if_gnt) if_req = 1'b0;
      if (got_d_gnt) d_req = 1'b0;
    end
    if (pend_if) begin if_req = 1'b1; pend_if = 0; end
    if (pend_d) begin d_req = 1'b1; pend_d = 0; end
    mem_gnt[sel]    = 1'b0;
    mem_rvalid[sel] = force_rvalid || (resp_pend && resp_en);
    mem_rdata[sel]  = rdata_cfg;
    resp_pend = 0;
    if (mem_req[sel] && !never_gnt && rstn) begin
      if (wcnt >= gnt_wait) begin
        mem_gnt[sel] = 1'b1; wcnt = 0; resp_pend = 1;
      end else begin
        wcnt++;
      end
    end
    #1;
    got_if_gnt = if_gnt[sel];
    got_d_gnt  = d_gnt[sel];
    if (got_if_gnt || got_d_gnt) begin
      own = got_d_gnt ? OWN_DATA : OWN_FETCH;
      n_grants++;
      if (got_d_gnt) d_gnt_cyc = cyc; else f_gnt_cyc = cyc;
      check("gnt_onehot", {got_if_gnt, got_d_gnt} == 2'b11, 1'b0);
      check("stall_at_gnt", stall[sel], 1'b1);
      check("gnt_order", own, (gnt_order.size() > 0) ? gnt_order.pop_front() : arb_owner_e'(~own));
      e.own  = own;
      e.data = (never_gnt || (got_d_gnt && d_we)) ? 32'd0 : rdata_cfg;
      e.err  = never_gnt;
      e.cyc  = (exp_lat > 0) ? cyc + exp_lat : -1;
      sb.push_back(e);
      $display("t=%0d dut%0d grant %s", cyc, sel, (own == OWN_DATA) ? "data" : "fetch");
    end
    if (if_rvalid[sel] || d_rvalid[sel]) begin
      if (sb.size() == 0) begin
        check("rvalid_unexpected", {if_rvalid[sel], d_rvalid[sel]}, 2'b00);
      end else begin
        e = sb.pop_front();
        n_resp++;
        check("rvalid_owner", {if_rvalid[sel], d_rvalid[sel]}, (e.own == OWN_DATA) ? 2'b01 : 2'b10);
        check("rdata", (e.own == OWN_DATA) ? d_rdata[sel] : if_rdata[sel], e.data);
        check("err", err[sel], e.err);
        if (e.cyc >= 0) check("rvalid_cycle", 160'(cyc), 160'(e.cyc));
        $display("t=%0d dut%0d resp %s rdata=%08h err=%0b", cyc, sel,
                 (e.own == OWN_DATA) ? "data" : "fetch",
                 (e.own == OWN_DATA) ? d_rdata[sel] : if_rdata[sel], err[sel]);
      end
    end else begin
      check("err_without_rvalid", err[sel], 1'b0);
    end
  endtask

  task automatic run_resp(input int target, input int budget);
    int b = 0;
    while (n_resp < target && b < budget) begin
      tick();
      b++;
    end
    check("resp_budget", 160'(n_resp), 160'(target));
  endtask

  task automatic do_reset();
    check("sb_empty", 160'(sb.size()), 160'd0);
    check("gnt_order_empty", 160'(gnt_order.size()), 160'd0);
    rstn = 1'b0; if_req = 1'b0; d_req = 1'b0;
    pend_if = 0; pend_d = 0; drop_all = 0; keep_req = 0;
    got_if_gnt = 0; got_d_gnt = 0; force_rvalid = 0;
    wcnt = 0; resp_pend = 0; never_gnt = 0; resp_en = 1; gnt_wait = 0;
    for (int k = 0; k < 2; k++) begin
      mem_gnt[k] = 1'b0; mem_rvalid[k] = 1'b0; mem_rdata[k] = '0;
    end
    tick();
    tick();
    rstn = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1, "simulation time limit");
  end

  initial begin
    int base;
    int reqc;
    rstn = 1'b0; if_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    d_be = 4'h0; if_addr = '0; d_addr = '0; d_wdata = '0;
    for (int k = 0; k < 2; k++) begin
      mem_gnt[k] = 1'b0; mem_rvalid[k] = 1'b0; mem_rdata[k] = '0;
    end

    do_reset();
    for (int k = 0; k < 2; k++) check($sformatf("reset_outs%0d", k), pack_outs(k), 160'd0);

    // Fetch only, immediate memory
    sel = 0; rdata_cfg = 32'h00500093; exp_lat = 3; if_addr = 32'h100;
    gnt_order.push_back(OWN_FETCH);
    pend_if = 1;
    tick();
    tick();
    check("t1_mem_req", mem_req[0], 1'b1);
    check("t1_mem_addr", mem_addr[0], 32'h100);
    check("t1_mem_be", mem_be[0], 4'hF);
    check("t1_mem_we", mem_we[0], 1'b0);
    run_resp(1, 20);
    tick();
    check("t1_idle_stall", stall[0], 1'b0);

    // Simultaneous requests, fixed priority
    do_reset();
    n_resp = 0; sel = 0; rdata_cfg = 32'h12345678; exp_lat = 3;
    d_we = 1'b0; d_be = 4'hF; d_addr = 32'h2000; if_addr = 32'h104;
    gnt_order.push_back(OWN_DATA);
    gnt_order.push_back(OWN_FETCH);
    pend_if = 1; pend_d = 1;
    run_resp(2, 30);
    check("t2_fetch_gnt_cycle", 160'(f_gnt_cyc), 160'(d_gnt_cyc + 3));

    // Round-robin with both held high
    do_reset();
    n_resp = 0; sel = 1; rdata_cfg = 32'hCAFE0001; exp_lat = 3;
    gnt_order.push_back(OWN_DATA);
    gnt_order.push_back(OWN_FETCH);
    gnt_order.push_back(OWN_DATA);
    gnt_order.push_back(OWN_FETCH);
    base = n_grants;
    keep_req = 1; pend_if = 1; pend_d = 1;
    for (int i = 0; i < 40 && n_grants < base + 4; i++) tick();
    check("t3_grants", 160'(n_grants - base), 160'd4);
    keep_req = 0; drop_all = 1;
    run_resp(4, 20);

    // Store with delayed memory grant
    do_reset();
    n_resp = 0; sel = 0; gnt_wait = 3; exp_lat = 6;
    d_we = 1'b1; d_be = 4'b0011; d_addr = 32'h40; d_wdata = 32'hAABBCCDD;
    gnt_order.push_back(OWN_DATA);
    pend_d = 1;
    tick();
    tick();
    check("t4_mem_be", mem_be[0], 4'b0011);
    check("t4_mem_wdata", mem_wdata[0], 32'hAABBCCDD);
    check("t4_mem_we", mem_we[0], 1'b1);
    reqc = 0;
    for (int i = 0; i < 12 && n_resp < 1; i++) begin
      if (mem_req[0]) reqc++;
      tick();
    end
    check("t4_req_cycles", 160'(reqc), 160'd4);
    check("t4_resp", 160'(n_resp), 160'd1);

    // Watchdog abort, then a late response in IDLE
    do_reset();
    n_resp = 0; sel = 0; never_gnt = 1; exp_lat = 9;
    d_we = 1'b0; d_be = 4'hF; d_addr = 32'h80;
    gnt_order.push_back(OWN_DATA);
    pend_d = 1;
    run_resp(1, 20);
    check("t5_mem_req_drop", mem_req[0], 1'b0);
    check("t5_stall_idle", stall[0], 1'b0);
    force_rvalid = 1;
    tick();
    force_rvalid = 0;
    tick();
    tick();
    check("t5_no_late_resp", 160'(n_resp), 160'd1);

    // Reset in WAIT_RESP, stale response afterwards
    do_reset();
    n_resp = 0; sel = 0; resp_en = 0; exp_lat = -1; rdata_cfg = 32'h5A5A5A5A;
    gnt_order.push_back(OWN_DATA);
    pend_d = 1;
    tick();
    tick();
    tick();
    check("t6_stall_wait", stall[0], 1'b1);
    sb.delete();
    rstn = 1'b0;
    tick();
    check("t6_reset_outs", pack_outs(0), 160'd0);
    rstn = 1'b1;
    force_rvalid = 1;
    tick();
    force_rvalid = 0;
    tick();
    tick();
    check("t6_no_stale_resp", 160'(n_resp), 160'd0);
    check("t6_idle_outs", pack_outs(0), 160'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
